// File: rtl/lvdci_rx_pkg.sv
// Shared constants for the LVDCI receive filter: FSM state encoding and
// legal parameter ranges, plus a small clamp helper for parameter sanitising.
package lvdci_rx_pkg;

  localparam logic [1:0] ST_DRIVE = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;

  localparam int FILT_LEN_MIN  = 1;
  localparam int FILT_LEN_MAX  = 16;
  localparam int BLANK_CYC_MIN = 0;
  localparam int BLANK_CYC_MAX = 255;

  localparam int CNT_W   = 4;
  localparam int BLANK_W = 8;

  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/lvdci_sync2.sv
// Two-flop synchronizer for the asynchronous pad level; both flops reset to INIT.
module lvdci_sync2 #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= INIT;
      q  <= INIT;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/lvdci_rx_filter.sv
// Receive-side level filter for a bidirectional LVDCI pad: blanks the input
// while our own driver is active and for a turnaround window afterwards.
module lvdci_rx_filter
  import lvdci_rx_pkg::*;
#(
  parameter int   FILT_LEN  = 3,
  parameter int   BLANK_CYC = 4,
  parameter logic INIT      = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic I,
  input  logic T,
  output logic O,
  output logic RISE,
  output logic FALL,
  output logic VALID,
  output logic GLITCH
);

  localparam int FL_EFF = clamp_int(FILT_LEN, FILT_LEN_MIN, FILT_LEN_MAX);
  localparam int BC_EFF = clamp_int(BLANK_CYC, BLANK_CYC_MIN, BLANK_CYC_MAX);

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(FL_EFF - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BC_EFF);
  localparam logic [BLANK_W-1:0] BLANK_ONE  = BLANK_W'(1);
  localparam logic [1:0]         ST_START   = (BC_EFF == 0) ? ST_TRACK : ST_BLANK;

  logic                s2;
  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [BLANK_W-1:0]  blank_cnt;

  lvdci_sync2 #(
    .INIT (INIT)
  ) u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (I),
    .q   (s2)
  );

  // Pulses default low every cycle; only the TRACK branch may raise them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_START;
      blank_cnt <= BLANK_LOAD;
      cnt       <= '0;
      O         <= INIT;
      RISE      <= 1'b0;
      FALL      <= 1'b0;
      GLITCH    <= 1'b0;
      VALID     <= 1'b0;
    end else begin
      RISE   <= 1'b0;
      FALL   <= 1'b0;
      GLITCH <= 1'b0;
      if (!T) begin
        // Own driver active: freeze O, even if a filter change completes now.
        state     <= ST_DRIVE;
        cnt       <= '0;
        blank_cnt <= '0;
        VALID     <= 1'b0;
      end else begin
        case (state)
          ST_DRIVE: begin
            cnt <= '0;
            if (BC_EFF == 0) begin
              state <= ST_TRACK;
              O     <= s2;
              VALID <= 1'b1;
            end else begin
              state     <= ST_BLANK;
              blank_cnt <= BLANK_LOAD;
              VALID     <= 1'b0;
            end
          end
          ST_BLANK: begin
            cnt <= '0;
            if (blank_cnt <= BLANK_ONE) begin
              state     <= ST_TRACK;
              blank_cnt <= '0;
              O         <= s2;
              VALID     <= 1'b1;
            end else begin
              blank_cnt <= blank_cnt - BLANK_ONE;
              VALID     <= 1'b0;
            end
          end
          ST_TRACK: begin
            VALID <= 1'b1;
            if (s2 != O) begin
              if (cnt == CNT_LAST) begin
                O    <= s2;
                cnt  <= '0;
                RISE <= s2;
                FALL <= ~s2;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end else if (cnt != '0) begin
              cnt    <= '0;
              GLITCH <= 1'b1;
            end
          end
          default: begin
            state <= ST_DRIVE;
            cnt   <= '0;
            VALID <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/lvdci_rx_filter.md
LVDCI_RX_FILTER -- requirements
Module: lvdci_rx_filter

Interface
REQ-001 SHALL have parameter FILT_LEN, default 3: consecutive differing samples needed to accept a new level (legal 1..16).
REQ-002 SHALL have parameter BLANK_CYC, default 4: turnaround blanking cycles after own driver releases (legal 0..255).
REQ-003 SHALL have parameter INIT, default 1'b0: reset level of synchronizer and O.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port I  input  1  pad input level, asynchronous to CLK.
REQ-007 SHALL have port T  input  1  own-driver tristate control, synchronous to CLK; 0 = own driver active, 1 = released.
REQ-008 SHALL have port O  output  1  filtered received level.
REQ-009 SHALL have port RISE  output  1  one-cycle pulse when O goes 0->1 through the filter.
REQ-010 SHALL have port FALL  output  1  one-cycle pulse when O goes 1->0 through the filter.
REQ-011 SHALL have port VALID  output  1  high only in TRACK.
REQ-012 SHALL have port GLITCH  output  1  one-cycle pulse when a pending level change is aborted.

Function
REQ-013 SHALL pass I through a 2-flop synchronizer (s1, s2); s2 is the only sampled value used downstream.
REQ-014 SHALL implement states DRIVE, BLANK, TRACK; state and all outputs registered.
REQ-015 SHALL, in any state with T=0, go to DRIVE next cycle, clear filter count and blank counter; T=0 has priority over every other event that cycle, including a completing filter change.
REQ-016 DRIVE: O holds its last value; VALID, RISE, FALL, GLITCH = 0; T=1 -> BLANK loaded with BLANK_CYC, or directly TRACK if BLANK_CYC=0.
REQ-017 BLANK: lasts exactly BLANK_CYC cycles with VALID=0, O held, no pulses; then -> TRACK.
REQ-018 On the transition into TRACK, O SHALL load s2 directly, with no RISE/FALL pulse and filter count cleared; VALID=1 from that cycle on.
REQ-019 TRACK, s2 != O: count increments; when count == FILT_LEN-1, O <= s2, count <= 0, matching RISE/FALL pulses in the same cycle O changes.
REQ-020 TRACK, s2 == O with count != 0: count <= 0, GLITCH pulses one cycle; with count == 0 nothing happens.
REQ-021 Latency: stable I change to O change SHALL be 2 + FILT_LEN cycles in TRACK; FILT_LEN=1 gives 3.
REQ-022 Filter count SHALL be 4 bits and never exceed FILT_LEN-1; no wrap-around possible.
REQ-023 RISE, FALL, GLITCH SHALL be mutually exclusive and never high outside TRACK.

Reset
REQ-024 RST=1 SHALL set s1, s2, O to INIT; RISE, FALL, GLITCH, VALID to 0; count to 0; state BLANK with BLANK_CYC loaded (TRACK if BLANK_CYC=0).
REQ-025 RST SHALL override T and all in-progress filtering or blanking in the same cycle.

Structure
REQ-026 State encoding (DRIVE, BLANK, TRACK) and the FILT_LEN/BLANK_CYC legal-range constants SHALL live in shared package lvdci_rx_pkg.
REQ-027 The synchronizer SHALL be a separate sub-module lvdci_sync2 (parameter INIT); remaining logic stays flat.

Verification
REQ-028 FILT_LEN=3, BLANK_CYC=4, T=1: after RST release VALID rises on cycle 4; I 0->1 held -> O=1 and RISE=1 exactly 5 cycles after I edge, one cycle only.
REQ-029 TRACK, O=0: I high for 2 cycles then low -> O stays 0, GLITCH pulses once, RISE never asserts.
REQ-030 TRACK: T=0 for 6 cycles while I toggles -> VALID=0 next cycle, O frozen, no pulses; T=1 -> 4 blank cycles, then O=current s2, VALID=1, no RISE/FALL.
REQ-031 T falls in the cycle a filter change would complete -> state DRIVE, O unchanged, no RISE/FALL.
REQ-032 BLANK_CYC=0, FILT_LEN=1: T 0->1 -> TRACK next cycle; I edge -> O changes 3 cycles later.
REQ-033 RST asserted mid-BLANK and mid-filter -> next cycle O=INIT, all pulses 0, VALID=0, blank restarts at 4.
